ram_nport_be: RTL and testbench

// Parametrised register-file RAM: NUM_RD asynchronous read ports and one synchronous write port

---
 rtl/ram_nport_be.sv | 111 +++++++++++
 tb/tb_ram_nport_be.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_nport_be.sv
// Multi-read-port register file with one byte-enabled write port, optional write-to-read
// bypass, and a clear sequencer that zeroes one word per cycle after reset or on request.
module ram_nport_be #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16,
   parameter int LANE_WIDTH = 8,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clear_req,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]       r_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]       r_data,
   input  logic                               write_enable,
   input  logic [ADDR_WIDTH-1:0]              w_addr,
   input  logic [DATA_WIDTH-1:0]              w_data,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   w_be,
   output logic                               busy,
   output logic                               wr_drop
);

   localparam int DEPTH     = 2 ** ADDR_WIDTH;
   localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   clr_ptr_reg, clr_ptr_next;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   wr_word;
   logic                    wr_commit;

   assign busy      = (state_reg == CLEAR);
   assign wr_drop   = write_enable & busy;
   assign wr_commit = write_enable & (state_reg == READY) & ~rst;

   always_comb begin
      state_next   = state_reg;
      clr_ptr_next = clr_ptr_reg;
      case (state_reg)
         CLEAR: begin
            clr_ptr_next = clr_ptr_reg + 1'b1;
            if (&clr_ptr_reg)
               state_next = READY;
         end
         READY: begin
            if (clear_req) begin
               state_next   = CLEAR;
               clr_ptr_next = '0;
            end
         end
         default: begin
            state_next   = CLEAR;
            clr_ptr_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= CLEAR;
         clr_ptr_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_ptr_reg <= clr_ptr_next;
      end
   end

   // Read-modify-write merge so disabled lanes keep their stored value.
   always_comb begin
      wr_word = mem[w_addr];
      for (int k = 0; k < NUM_LANES; k++) begin
         if (w_be[k])
            wr_word[k*LANE_WIDTH +: LANE_WIDTH] = w_data[k*LANE_WIDTH +: LANE_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_reg == CLEAR)
            mem[clr_ptr_reg] <= '0;
         else if (wr_commit)
            mem[w_addr] <= wr_word;
      end
   end

   genvar gi, gl;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] ra;
         logic                  hit;
         logic [DATA_WIDTH-1:0] word;

         assign ra  = r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign hit = (BYPASS != 0) && wr_commit && (ra == w_addr);

         for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
            assign word[gl*LANE_WIDTH +: LANE_WIDTH] = (hit && w_be[gl]) ?
                   w_data[gl*LANE_WIDTH +: LANE_WIDTH] : mem[ra][gl*LANE_WIDTH +: LANE_WIDTH];
         end

         // Contents are undefined mid-sweep, so reads are forced to zero while busy.
         assign r_data[gi*DATA_WIDTH +: DATA_WIDTH] = busy ? '0 : word;
      end
   endgenerate

endmodule

// File: tb/tb_ram_nport_be.sv
// Scoreboard bench for ram_nport_be: one bypassing and one non-bypassing instance share
// stimulus; a word-level reference model predicts every output each cycle.
module tb_ram_nport_be;

   localparam int AW = 3;
   localparam int DW = 16;
   localparam int LW = 8;
   localparam int NR = 2;
   localparam int NL = DW / LW;
   localparam int DEPTH = 2 ** AW;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear_req;
   logic [NR*AW-1:0]  r_addr;
   logic [NR*DW-1:0]  r_data_b, r_data_nb;
   logic              write_enable;
   logic [AW-1:0]     w_addr;
   logic [DW-1:0]     w_data;
   logic [NL-1:0]     w_be;
   logic              busy_b, busy_nb, wr_drop_b, wr_drop_nb;

   always #5 clk = ~clk;

   ram_nport_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .NUM_RD(NR), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .clear_req(clear_req), .r_addr(r_addr), .r_data(r_data_b),
      .write_enable(write_enable), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
      .busy(busy_b), .wr_drop(wr_drop_b));

   ram_nport_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .NUM_RD(NR), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .clear_req(clear_req), .r_addr(r_addr), .r_data(r_data_nb),
      .write_enable(write_enable), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
      .busy(busy_nb), .wr_drop(wr_drop_nb));

   typedef struct {
      logic [NR*DW-1:0] rd_b;
      logic [NR*DW-1:0] rd_nb;
      logic             busy;
      logic             drop;
      bit               fix_en;
      logic [DW-1:0]    fix_val;
      int               cyc;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc_no = 0;

   // Reference model: plain word array plus a sweep position (-1 when not clearing).
   logic [DW-1:0] mm [DEPTH];
   int            sweep_pos = -1;
   bit            fix_pending = 0;
   logic [DW-1:0] fix_pending_val;

   function automatic logic [DW-1:0] mread(bit bp, int ra, bit r, bit we, int wa,
                                           logic [DW-1:0] wd, logic [NL-1:0] be);
      logic [DW-1:0] w;
      if (sweep_pos >= 0) return '0;
      w = mm[ra];
      for (int k = 0; k < NL; k++)
         if (bp && we && !r && wa == ra && be[k]) w[k*LW +: LW] = wd[k*LW +: LW];
      return w;
   endfunction

   task automatic cycle(input bit r, input bit cr, input bit we, input int wa,
                        input logic [DW-1:0] wd, input logic [NL-1:0] be,
                        input int ra0, input int ra1);
      exp_t e;
      int   ra;
      rst          = r;
      clear_req    = cr;
      write_enable = we;
      w_addr       = AW'(wa);
      w_data       = wd;
      w_be         = be;
      r_addr       = {AW'(ra1), AW'(ra0)};
      e.busy    = (sweep_pos >= 0);
      e.drop    = we && (sweep_pos >= 0);
      e.fix_en  = fix_pending;
      e.fix_val = fix_pending_val;
      e.cyc     = cyc_no;
      fix_pending = 0;
      for (int p = 0; p < NR; p++) begin
         ra = (p == 0) ? ra0 : ra1;
         e.rd_b[p*DW +: DW]  = mread(1, ra, r, we, wa, wd, be);
         e.rd_nb[p*DW +: DW] = mread(0, ra, r, we, wa, wd, be);
      end
      q.push_back(e);
      // Advance model across the coming edge.
      if (r) begin
         sweep_pos = 0;
      end else if (sweep_pos >= 0) begin
         mm[sweep_pos] = '0;
         sweep_pos = (sweep_pos == DEPTH - 1) ? -1 : sweep_pos + 1;
      end else begin
         if (we)
            for (int k = 0; k < NL; k++)
               if (be[k]) mm[wa][k*LW +: LW] = wd[k*LW +: LW];
         if (cr) sweep_pos = 0;
      end
      cyc_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_fix(input logic [DW-1:0] v);
      fix_pending     = 1;
      fix_pending_val = v;
   endtask

   task automatic chk(input string name, input int cyc, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         for (int p = 0; p < NR; p++) begin
            chk($sformatf("rd%0d_byp", p), e.cyc, r_data_b[p*DW +: DW], e.rd_b[p*DW +: DW]);
            chk($sformatf("rd%0d_nobyp", p), e.cyc, r_data_nb[p*DW +: DW], e.rd_nb[p*DW +: DW]);
            if (e.fix_en)
               chk($sformatf("rd%0d_fixed", p), e.cyc, r_data_b[p*DW +: DW], e.fix_val);
         end
         chk("busy_byp", e.cyc, DW'(busy_b), DW'(e.busy));
         chk("busy_nobyp", e.cyc, DW'(busy_nb), DW'(e.busy));
         chk("wr_drop_byp", e.cyc, DW'(wr_drop_b), DW'(e.drop));
         chk("wr_drop_nobyp", e.cyc, DW'(wr_drop_nb), DW'(e.drop));
      end
   end

   initial begin
      int wa, ra0, ra1;
      logic [DW-1:0] wd;
      logic [NL-1:0] be;
      bit r, cr, we;

      rst = 1; clear_req = 0; write_enable = 0; w_addr = '0; w_data = '0; w_be = '0; r_addr = '0;
      @(posedge clk);
      #1;
      sweep_pos = 0;

      // Reset, then full sweep and readback of every word.
      cycle(1, 0, 0, 0, 16'h0, 2'b00, 0, 7);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 16'h0, 2'b00, i, 7 - i);
      for (int i = 0; i < DEPTH; i++) begin
         expect_fix(16'h0000);
         cycle(0, 0, 0, 0, 16'h0, 2'b00, i, (i + 3) % DEPTH);
      end

      // Byte-lane merge.
      cycle(0, 0, 1, 3, 16'hBEEF, 2'b11, 0, 1);
      cycle(0, 0, 1, 3, 16'h1234, 2'b10, 0, 1);
      expect_fix(16'h12EF);
      cycle(0, 0, 0, 0, 16'h0, 2'b00, 3, 3);

      // Bypass of a single enabled lane.
      expect_fix(16'h00A5);
      cycle(0, 0, 1, 5, 16'hA5A5, 2'b01, 5, 5);
      expect_fix(16'h00A5);
      cycle(0, 0, 0, 0, 16'h0, 2'b00, 5, 5);
      cycle(0, 0, 1, 6, 16'hFFFF, 2'b00, 6, 6);

      // Write alongside clear_req commits; writes while busy are dropped.
      cycle(0, 0, 1, 2, 16'h1111, 2'b11, 2, 4);
      cycle(0, 1, 1, 4, 16'h2222, 2'b11, 4, 2);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, i, 16'h5A5A, 2'b11, i, 4);
      for (int i = 0; i < DEPTH; i++) begin
         expect_fix(16'h0000);
         cycle(0, 0, 0, 0, 16'h0, 2'b00, i, 2);
      end

      // Reset mid-sweep restarts it; clear_req during the sweep is ignored.
      cycle(0, 0, 1, 1, 16'h7777, 2'b11, 1, 1);
      cycle(0, 1, 0, 0, 16'h0, 2'b00, 1, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 16'h0, 2'b00, i, 1);
      cycle(1, 0, 0, 0, 16'h0, 2'b00, 0, 1);
      for (int i = 0; i < DEPTH + 2; i++) cycle(0, (i % 3) == 1, 0, 0, 16'h0, 2'b00, i % DEPTH, 1);

      // Randomized traffic.
      for (int n = 0; n < 2000; n++) begin
         r   = ($urandom_range(0, 199) == 0);
         cr  = ($urandom_range(0, 49) == 0);
         we  = $urandom_range(0, 1);
         wa  = $urandom_range(0, DEPTH - 1);
         wd  = DW'($urandom);
         be  = NL'($urandom);
         ra0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, DEPTH - 1);
         ra1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, DEPTH - 1);
         cycle(r, cr, we, wa, wd, be, ra0, ra1);
      end

      @(negedge clk);
      #1;
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
